oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sequencer that copies a block of words from data memory into OAM.
- Shares the data-memory port and the OAM write port with the CPU by cycle stealing. The CPU always has priority.
- Sits beside the CPU memory stage and muxes the memory port with the CPU's MemRead/MemWrite path via mem_sel.
- A transfer is launched by a one-cycle dma_start command.

Parameters:
- ADDR_W, 16, data-memory address width.
- DATA_W, 32, word width (memory and OAM).
- OAM_AW, 8, OAM address width.
- STARVE_LIMIT, 8, consecutive denied cycles before forced grant (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- dma_start  in  1  start pulse; ignored while busy.
- dma_src  in  ADDR_W  first source word address.
- dma_dst  in  OAM_AW  first OAM index.
- dma_len  in  OAM_AW+1  word count; 0 is legal.
- cpu_mem_req  in  1  CPU MemRead|MemWrite this cycle.
- cpu_oam_we  in  1  CPU OAMWrite this cycle.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_re.
- mem_sel  out  1  1 = DMA owns memory port this cycle.
- mem_re  out  1  DMA read strobe.
- mem_addr  out  ADDR_W  DMA read address.
- oam_we  out  1  DMA OAM write strobe.
- oam_addr  out  OAM_AW  OAM write index.
- oam_wdata  out  DATA_W  OAM write data.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- cpu_stall  out  1  CPU must hold its memory access (optional feature).

Behaviour:
- FSM states: IDLE, RD, CAP, WR, FIN. Registers: state, src_ptr, dst_ptr, remaining, wbuf, starve_cnt.
- Reset (rst_n=0 at an edge): state=IDLE, all pointers/counters/wbuf=0. Every output is 0 in the cycle after reset, and while in IDLE. Reset mid-transfer aborts silently: no done pulse, no further strobes.
- IDLE: on dma_start, load src_ptr=dma_src, dst_ptr=dma_dst, remaining=dma_len. Go to RD if dma_len!=0, else go to FIN.
- RD: grant = !cpu_mem_req. If granted: mem_sel=1, mem_re=1, mem_addr=src_ptr; go to CAP. If not granted: hold in RD with no strobes.
- CAP: wbuf <= mem_rdata; go to WR.
- WR: if !cpu_oam_we, then oam_we=1, oam_addr=dst_ptr, oam_wdata=wbuf; src_ptr++, dst_ptr++, remaining--. Then go to FIN if remaining was 1, else RD. If cpu_oam_we=1, hold in WR with oam_we=0.
- FIN: done=1 for exactly one cycle; go to IDLE.
- busy=1 in every state except IDLE.
- Output timing: mem_sel/mem_re/mem_addr/oam_* are combinational from state, pointers and the cpu_* inputs, so the grant applies in the same cycle.
- Throughput: 3 cycles per word uncontested. Total = 3*len + 1 cycles from the start edge to done.
- Wrap-around: src_ptr wraps mod 2^ADDR_W; dst_ptr wraps mod 2^OAM_AW. Lengths up to 2^OAM_AW are legal. Larger lengths overwrite OAM modulo its size.
- Simultaneous events:
  - CPU request in the same cycle the DMA wants the port: the CPU wins.
  - dma_start while busy is dropped.
  - dma_start in the FIN cycle is dropped.

Optional Feature:
- Macro: OAM_DMA_STARVE_GUARD_EN.
- Defined:
  - starve_cnt counts consecutive denied RD cycles.
  - When starve_cnt==STARVE_LIMIT, the DMA issues the read regardless of cpu_mem_req, with cpu_stall=1 for that cycle.
  - starve_cnt clears on any issue.
  - The OAM port is not guarded.
- Undefined: cpu_stall tied 0, starve_cnt absent, and the DMA can wait indefinitely.

Decomposition:
- Shared package gpu_dma_pkg: FSM state enum (IDLE/RD/CAP/WR/FIN) and default width constants (ADDR_W, DATA_W, OAM_AW).
- No sub-module. The optional starvation counter is local logic inside the macro guard.

Test Plan:
- 4-word uncontested, src=0x0100, dst=0x10, start at edge 0:
  - mem_re in cycles 1, 4, 7, 10 at addresses 0x100–0x103.
  - oam_we in cycles 3, 6, 9, 12 at indices 0x10–0x13 with the returned data.
  - done in cycle 13; busy high in cycles 1–13.
- cpu_mem_req held high for cycles 1–5, len=1: RD holds with mem_sel=0; mem_re in cycle 6, oam_we in cycle 8, done in cycle 9.
- cpu_oam_we high during the first WR cycle: oam_we delayed one cycle; data and index unchanged; remaining decrements once.
- len=0: done in cycle 1, no mem_re/oam_we. Also dst=0xFE, len=4: writes to 0xFE, 0xFF, 0x00, 0x01.
- rst_n low in cycle 5 of a 4-word transfer: all outputs 0 from cycle 6, no done pulse. A new dma_start afterwards runs normally.
- With OAM_DMA_STARVE_GUARD_EN, STARVE_LIMIT=8, cpu_mem_req stuck high: read issued on the 9th RD cycle with cpu_stall=1 for one cycle. Without the macro: no issue, cpu_stall=0.

Source files
------------

// File: rtl/gpu_dma_pkg.sv
// rtl/gpu_dma_pkg.sv - shared types and default widths for the OAM DMA controller
//
// Purpose: FSM state encoding and default width constants used by the
// oam_dma_ctrl interface, the controller and its testbench.
// Ports: none (package).
package gpu_dma_pkg;

  localparam int DMA_ADDR_W       = 16;  // data-memory address width
  localparam int DMA_DATA_W       = 32;  // memory / OAM word width
  localparam int DMA_OAM_AW       = 8;   // OAM index width
  localparam int DMA_STARVE_LIMIT = 8;   // denied RD cycles before a forced read

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// rtl/oam_dma_ctrl_if.sv - command, CPU-arbitration, memory and OAM signals of the OAM DMA
//
// Purpose: bundles every non-clock/reset signal of oam_dma_ctrl.
// Ports (signals):
//   command : dma_start, dma_src, dma_dst, dma_len
//   CPU     : cpu_mem_req, cpu_oam_we, cpu_stall
//   memory  : mem_sel, mem_re, mem_addr, mem_rdata
//   OAM     : oam_we, oam_addr, oam_wdata
//   status  : busy, done
// Modports: master = the DMA controller, slave = CPU/memory side driving it.
interface oam_dma_ctrl_if
  import gpu_dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W,
  parameter int OAM_AW = DMA_OAM_AW
) ();

  logic              dma_start;
  logic [ADDR_W-1:0] dma_src;
  logic [OAM_AW-1:0] dma_dst;
  logic [OAM_AW:0]   dma_len;
  logic              cpu_mem_req;
  logic              cpu_oam_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_sel;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic              oam_we;
  logic [OAM_AW-1:0] oam_addr;
  logic [DATA_W-1:0] oam_wdata;
  logic              busy;
  logic              done;
  logic              cpu_stall;

  modport master (
    input  dma_start, dma_src, dma_dst, dma_len,
    input  cpu_mem_req, cpu_oam_we, mem_rdata,
    output mem_sel, mem_re, mem_addr,
    output oam_we, oam_addr, oam_wdata,
    output busy, done, cpu_stall
  );

  modport slave (
    output dma_start, dma_src, dma_dst, dma_len,
    output cpu_mem_req, cpu_oam_we, mem_rdata,
    input  mem_sel, mem_re, mem_addr,
    input  oam_we, oam_addr, oam_wdata,
    input  busy, done, cpu_stall
  );

endinterface

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - cycle-stealing DMA that copies data-memory words into OAM
//
// Purpose: on a dma_start pulse, copies dma_len words from data memory
// (starting at dma_src) into OAM (starting at dma_dst), one word per
// RD -> CAP -> WR sequence, yielding to the CPU whenever it uses the
// memory port or the OAM write port.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : oam_dma_ctrl_if.master (command, CPU arbitration, memory, OAM, status)
// Optional feature: define OAM_DMA_STARVE_GUARD_EN to force a read (with
// cpu_stall) after STARVE_LIMIT consecutive denied RD cycles.
module oam_dma_ctrl
  import gpu_dma_pkg::*;
#(
  parameter int ADDR_W       = DMA_ADDR_W,
  parameter int DATA_W       = DMA_DATA_W,
  parameter int OAM_AW       = DMA_OAM_AW,
  parameter int STARVE_LIMIT = DMA_STARVE_LIMIT
) (
  input logic           clk,
  input logic           rst_n,
  oam_dma_ctrl_if.master bus
);

  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("oam_dma_ctrl: STARVE_LIMIT must be at least 1");
  end

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [OAM_AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [OAM_AW:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;

  // High when the starvation guard overrides the CPU for this RD cycle.
  logic force_rd;
  // High in any RD cycle where the read actually goes out.
  logic rd_issue;

`ifdef OAM_DMA_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_rd = (starve_cnt_q == SC_W'(STARVE_LIMIT));

  // Counts consecutive RD cycles lost to the CPU; any issued read restarts it.
  // It can never pass STARVE_LIMIT because reaching it forces the issue.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == RD) begin
      if (rd_issue) begin
        starve_cnt_d = '0;
      end else begin
        starve_cnt_d = starve_cnt_q + SC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_rd = 1'b0;
`endif

  assign rd_issue = (state_q == RD) && (!bus.cpu_mem_req || force_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      wbuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      wbuf_q      <= wbuf_d;
    end
  end

  // Next state and all outputs. Outputs are decoded combinationally so the
  // CPU's request takes effect in the very cycle it is raised. Address and
  // data outputs are zero whenever their strobe is low.
  always_comb begin
    state_d       = state_q;
    src_ptr_d     = src_ptr_q;
    dst_ptr_d     = dst_ptr_q;
    remaining_d   = remaining_q;
    wbuf_d        = wbuf_q;
    bus.mem_sel   = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    bus.oam_we    = 1'b0;
    bus.oam_addr  = '0;
    bus.oam_wdata = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.cpu_stall = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.dma_start) begin
          src_ptr_d   = bus.dma_src;
          dst_ptr_d   = bus.dma_dst;
          remaining_d = bus.dma_len;
          state_d     = (bus.dma_len != '0) ? RD : FIN;
        end
      end

      RD: begin
        bus.busy = 1'b1;
        if (rd_issue) begin
          bus.mem_sel   = 1'b1;
          bus.mem_re    = 1'b1;
          bus.mem_addr  = src_ptr_q;
          // Only a real collision needs the CPU held back.
          bus.cpu_stall = force_rd && bus.cpu_mem_req;
          state_d       = CAP;
        end
      end

      CAP: begin
        bus.busy = 1'b1;
        wbuf_d   = bus.mem_rdata;
        state_d  = WR;
      end

      WR: begin
        bus.busy = 1'b1;
        if (!bus.cpu_oam_we) begin
          bus.oam_we    = 1'b1;
          bus.oam_addr  = dst_ptr_q;
          bus.oam_wdata = wbuf_q;
          src_ptr_d     = src_ptr_q + ADDR_W'(1);
          dst_ptr_d     = dst_ptr_q + OAM_AW'(1);
          remaining_d   = remaining_q - (OAM_AW+1)'(1);
          state_d       = (remaining_q == (OAM_AW+1)'(1)) ? FIN : RD;
        end
      end

      FIN: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - self-checking bench for oam_dma_ctrl
module tb_oam_dma_ctrl;
  import gpu_dma_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int OW = 8;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  oam_dma_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .OAM_AW(OW)) bus ();

  oam_dma_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .OAM_AW(OW), .STARVE_LIMIT(SL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Memory contents: every address holds a distinct, address-derived word.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, a ^ 16'hA5C3};
  endfunction

  // Read data returns one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= mem_word(bus.mem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {2'b00, bus.mem_sel, bus.mem_re, bus.mem_addr, bus.oam_we, bus.oam_addr,
            bus.oam_wdata, bus.busy, bus.done, bus.cpu_stall};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [AW-1:0] s, input logic [OW-1:0] d,
                       input logic [OW:0] l, input logic mr, input logic ow);
    bus.dma_start   = st;
    bus.dma_src     = s;
    bus.dma_dst     = d;
    bus.dma_len     = l;
    bus.cpu_mem_req = mr;
    bus.cpu_oam_we  = ow;
  endtask

  // One transfer against a queue model of the reads and writes the copy must
  // produce; CPU contention and spurious start pulses are random percentages.
  task automatic run_xfer(input logic [AW-1:0] src, input logic [OW-1:0] dst,
                          input logic [OW:0] len, input int pm, input int po,
                          input int pj, output int lat);
    logic [AW-1:0] rq[$];
    logic [OW-1:0] wi[$];
    logic [DW-1:0] wd[$];
    logic mr, ow, js, done_seen;
    int bound;
    for (int i = 0; i < int'(len); i++) begin
      rq.push_back(AW'(int'(src) + i));
      wi.push_back(OW'(int'(dst) + i));
      wd.push_back(mem_word(AW'(int'(src) + i)));
    end
    tick();
    drive(1'b1, src, dst, len, 1'b0, 1'b0);
    #1;
    lat = 0;
    done_seen = 1'b0;
    bound = 40 * int'(len) + 20;
    while (!done_seen && lat < bound) begin
      lat++;
      tick();
      mr = ($urandom_range(99) < pm);
      ow = ($urandom_range(99) < po);
      js = ($urandom_range(99) < pj);
      drive(js, AW'($urandom), OW'($urandom), (OW+1)'($urandom), mr, ow);
      #1;
      chk("x_busy", bus.busy, 1);
      if (bus.mem_sel || bus.mem_re) chk("x_sel_eq_re", bus.mem_sel, bus.mem_re);
      if (bus.mem_re) begin
        chk("x_cpu_priority", mr && !bus.cpu_stall, 0);
        chk("x_extra_read", rq.size() != 0, 1);
        if (rq.size() != 0) chk("x_rd_addr", bus.mem_addr, rq.pop_front());
      end
      if (bus.oam_we) begin
        chk("x_oam_priority", ow, 0);
        chk("x_extra_write", wi.size() != 0, 1);
        if (wi.size() != 0) begin
          chk("x_wr_idx", bus.oam_addr, wi.pop_front());
          chk("x_wr_data", bus.oam_wdata, wd.pop_front());
        end
      end
      if (bus.done) begin
        done_seen = 1'b1;
        chk("x_reads_left", rq.size(), 0);
        chk("x_writes_left", wi.size(), 0);
      end
    end
    if (!done_seen) chk("x_timeout", 0, 1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("x_idle_after", all_outs(), 0);
  endtask

  int lat;

  initial begin
    // Reset
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_outs", all_outs(), 0);
    rst_n = 1'b1;

    // 4 words uncontested, with a start pulse in the FIN cycle that must be dropped
    tick();
    drive(1'b1, 16'h0100, 8'h10, 9'd4, 1'b0, 1'b0);
    #1;
    for (int c = 1; c <= 14; c++) begin
      logic ere, ewe;
      tick();
      drive(c == 13, 16'h0BAD, 8'h77, 9'd3, 1'b0, 1'b0);
      #1;
      ere = (c <= 10) && ((c - 1) % 3 == 0);
      ewe = (c >= 3) && (c <= 12) && (c % 3 == 0);
      chk($sformatf("t1_c%0d_re", c), bus.mem_re, ere);
      if (ere) chk($sformatf("t1_c%0d_raddr", c), bus.mem_addr, 16'h0100 + (c - 1) / 3);
      chk($sformatf("t1_c%0d_we", c), bus.oam_we, ewe);
      if (ewe) begin
        chk($sformatf("t1_c%0d_widx", c), bus.oam_addr, 8'h10 + (c - 3) / 3);
        chk($sformatf("t1_c%0d_wdata", c), bus.oam_wdata, mem_word(AW'(16'h0100 + (c - 3) / 3)));
      end
      chk($sformatf("t1_c%0d_busy", c), bus.busy, (c <= 13));
      chk($sformatf("t1_c%0d_done", c), bus.done, (c == 13));
    end

    // CPU holds the memory port for cycles 1-5, len=1
    tick();
    drive(1'b1, 16'h2000, 8'h40, 9'd1, 1'b0, 1'b0);
    #1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      drive(1'b0, '0, '0, '0, (c <= 5), 1'b0);
      #1;
      chk($sformatf("t2_c%0d_sel", c), bus.mem_sel, (c == 6));
      chk($sformatf("t2_c%0d_re", c), bus.mem_re, (c == 6));
      if (c == 6) chk("t2_raddr", bus.mem_addr, 16'h2000);
      chk($sformatf("t2_c%0d_we", c), bus.oam_we, (c == 8));
      if (c == 8) begin
        chk("t2_widx", bus.oam_addr, 8'h40);
        chk("t2_wdata", bus.oam_wdata, mem_word(16'h2000));
      end
      chk($sformatf("t2_c%0d_done", c), bus.done, (c == 9));
      chk($sformatf("t2_c%0d_busy", c), bus.busy, (c <= 9));
    end

    // CPU writes OAM during the first WR cycle, len=2
    tick();
    drive(1'b1, 16'h3000, 8'h80, 9'd2, 1'b0, 1'b0);
    #1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      drive(1'b0, '0, '0, '0, 1'b0, (c == 3));
      #1;
      chk($sformatf("t3_c%0d_re", c), bus.mem_re, (c == 1 || c == 5));
      chk($sformatf("t3_c%0d_we", c), bus.oam_we, (c == 4 || c == 7));
      if (c == 4) begin
        chk("t3_widx0", bus.oam_addr, 8'h80);
        chk("t3_wdata0", bus.oam_wdata, mem_word(16'h3000));
      end
      if (c == 7) begin
        chk("t3_widx1", bus.oam_addr, 8'h81);
        chk("t3_wdata1", bus.oam_wdata, mem_word(16'h3001));
      end
      chk($sformatf("t3_c%0d_done", c), bus.done, (c == 8));
    end

    // len=0: done straight away, no strobes
    tick();
    drive(1'b1, 16'h4000, 8'h00, 9'd0, 1'b0, 1'b0);
    #1;
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("t4_len0_c1", all_outs(), 64'h6);
    tick();
    #1;
    chk("t4_len0_c2", all_outs(), 0);

    // Both pointers wrap, uncontested: 3*len+1 cycles
    run_xfer(16'hFFFE, 8'hFE, 9'd4, 0, 0, 0, lat);
    chk("t4_wrap_latency", lat, 13);

    // Reset in cycle 5 of a 4-word transfer
    tick();
    drive(1'b1, 16'h0500, 8'h20, 9'd4, 1'b0, 1'b0);
    #1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      rst_n = (c != 5);
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      #1;
      if (c >= 6) chk($sformatf("t5_c%0d_abort", c), all_outs(), 0);
    end
    run_xfer(16'h0600, 8'h30, 9'd3, 0, 0, 0, lat);
    chk("t5_restart_latency", lat, 10);

    // Random transfers with CPU contention and spurious start pulses
    for (int k = 0; k < 8; k++) begin
      run_xfer(AW'($urandom), OW'($urandom), (OW+1)'($urandom_range(40, 1)),
               $urandom_range(50), $urandom_range(50), 25, lat);
    end
    run_xfer(AW'($urandom), OW'($urandom), 9'd256, 30, 30, 10, lat);

    // Memory port permanently requested by the CPU
    tick();
    drive(1'b1, 16'h7000, 8'h03, 9'd1, 1'b0, 1'b0);
    #1;
`ifdef OAM_DMA_STARVE_GUARD_EN
    for (int c = 1; c <= 13; c++) begin
      tick();
      drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
      #1;
      chk($sformatf("t6_c%0d_re", c), bus.mem_re, (c == SL + 1));
      chk($sformatf("t6_c%0d_stall", c), bus.cpu_stall, (c == SL + 1));
      if (c == SL + 1) chk("t6_raddr", bus.mem_addr, 16'h7000);
      chk($sformatf("t6_c%0d_we", c), bus.oam_we, (c == SL + 3));
      chk($sformatf("t6_c%0d_done", c), bus.done, (c == SL + 4));
    end
`else
    for (int c = 1; c <= 30; c++) begin
      tick();
      drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
      #1;
      chk($sformatf("t6_c%0d_re", c), bus.mem_re, 0);
      chk($sformatf("t6_c%0d_stall", c), bus.cpu_stall, 0);
      chk($sformatf("t6_c%0d_busy", c), bus.busy, 1);
    end
    for (int c = 31; c <= 35; c++) begin
      tick();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      #1;
      chk($sformatf("t6_c%0d_re", c), bus.mem_re, (c == 31));
      chk($sformatf("t6_c%0d_we", c), bus.oam_we, (c == 33));
      chk($sformatf("t6_c%0d_done", c), bus.done, (c == 34));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
